// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM frame multiplexer: word constants,
// FSM state encoding and the slot-index width helper.
package tdm_pkg;

    localparam int DATA_W_DEF = 4;
    localparam logic [DATA_W_DEF-1:0] SYNC_WORD_DEF = 4'hA;
    localparam logic [DATA_W_DEF-1:0] IDLE_WORD_DEF = 4'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } tdm_state_e;

    // Slot 0 is the sync slot, so NUM_CH data slots need NUM_CH+1 codes.
    function automatic int slot_w(input int num_ch);
        return $clog2(num_ch + 1);
    endfunction

endpackage

// File: rtl/tdm_frame_mux_if.sv
// Channel-side and queue-side signals of the frame multiplexer, plus the
// FSM state for observation.
interface tdm_frame_mux_if
    import tdm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = DATA_W_DEF
);
    localparam int SLOT_W = slot_w(NUM_CH);

    logic                     en;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH-1:0]        ch_ack;
    logic [DATA_W-1:0]        out_data;
    logic                     out_wen;
    logic                     frame_start;
    logic [SLOT_W-1:0]        slot;
    tdm_state_e               state;

    modport master (
        input  en, ch_data, ch_valid,
        output ch_ack, out_data, out_wen, frame_start, slot, state
    );

    modport slave (
        output en, ch_data, ch_valid,
        input  ch_ack, out_data, out_wen, frame_start, slot, state
    );

endinterface

// File: rtl/tdm_slot_counter.sv
// Enabled modulo-NUM_CH counter selecting the data slot; wrap is high while
// the count sits on the last channel.
module tdm_slot_counter #(
    parameter int NUM_CH = 4,
    localparam int K_W = $clog2(NUM_CH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           inc,
    output logic [K_W-1:0] count,
    output logic           wrap
);

    assign wrap = (count == K_W'(NUM_CH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + K_W'(1);
        end
    end

endmodule

// File: rtl/tdm_frame_mux.sv
// Interleaves NUM_CH channel words into frames of one sync word followed by
// NUM_CH data words, one word per enabled clock, feeding the TDM queue.
module tdm_frame_mux
    import tdm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = DATA_W_DEF,
    parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(SYNC_WORD_DEF),
    parameter logic [DATA_W-1:0] IDLE_WORD = DATA_W'(IDLE_WORD_DEF)
) (
    input logic              clk,
    input logic              rst,
    tdm_frame_mux_if.master  bus
);

    localparam int K_W    = $clog2(NUM_CH);
    localparam int SLOT_W = slot_w(NUM_CH);

    // Handshake: ch_valid/ch_data are sampled only on an enabled SYNC edge;
    // ch_ack pulses for that one cycle on each captured channel. out_wen
    // qualifies out_data; the only backpressure is the shared en.
    tdm_state_e state_q, state_d;

    logic [K_W-1:0]           k;
    logic                     k_wrap, k_inc, k_clr;
    logic [NUM_CH*DATA_W-1:0] snap_q;
    logic [NUM_CH-1:0]        mask_q;
    logic [DATA_W-1:0]        slot_word;

    logic [DATA_W-1:0] out_data_q;
    logic              out_wen_q, frame_start_q;
    logic [SLOT_W-1:0] slot_q;
    logic [NUM_CH-1:0] ch_ack_q;

    tdm_slot_counter #(.NUM_CH(NUM_CH)) u_slot_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (k_clr),
        .inc   (k_inc),
        .count (k),
        .wrap  (k_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        k_inc   = 1'b0;
        k_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                k_clr = 1'b1;
                if (bus.en) state_d = SYNC;
            end
            SYNC: begin
                if (bus.en) state_d = DATA;
            end
            DATA: begin
                if (bus.en) begin
                    k_inc = 1'b1;
                    if (k_wrap) state_d = SYNC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        slot_word = IDLE_WORD;
        if (mask_q[k]) slot_word = snap_q[k*DATA_W +: DATA_W];
    end

    // A stalled edge drops the strobes but leaves word, slot and flag as-is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q    <= '0;
            out_wen_q     <= 1'b0;
            frame_start_q <= 1'b0;
            slot_q        <= '0;
            ch_ack_q      <= '0;
            snap_q        <= '0;
            mask_q        <= '0;
        end else begin
            out_wen_q <= 1'b0;
            ch_ack_q  <= '0;
            if (bus.en) begin
                case (state_q)
                    SYNC: begin
                        out_data_q    <= SYNC_WORD;
                        out_wen_q     <= 1'b1;
                        frame_start_q <= 1'b1;
                        slot_q        <= '0;
                        snap_q        <= bus.ch_data;
                        mask_q        <= bus.ch_valid;
                        ch_ack_q      <= bus.ch_valid;
                    end
                    DATA: begin
                        out_data_q    <= slot_word;
                        out_wen_q     <= 1'b1;
                        frame_start_q <= 1'b0;
                        slot_q        <= SLOT_W'(k) + SLOT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.out_data    = out_data_q;
    assign bus.out_wen     = out_wen_q;
    assign bus.frame_start = frame_start_q;
    assign bus.slot        = slot_q;
    assign bus.ch_ack      = ch_ack_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_tdm_frame_mux.sv
// Directed bench for tdm_frame_mux: frame-position model checked every cycle,
// an expected-word queue for written streams, and literal spot checks.
module tb_tdm_frame_mux;
  import tdm_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 4;
  localparam logic [DATA_W-1:0] SYNC_VAL = 4'hA;
  localparam logic [DATA_W-1:0] IDLE_VAL = 4'h0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tdm_frame_mux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  tdm_frame_mux #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SYNC_WORD(SYNC_VAL), .IDLE_WORD(IDLE_VAL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- counters / check helper ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-position model ----------------
  // m_pos counts enabled edges into the frame: 0 = sync slot, p = channel p-1.
  bit                m_started;
  int                m_pos;
  logic [DATA_W-1:0] m_snap [NUM_CH];
  logic [NUM_CH-1:0] m_mask;
  logic [DATA_W-1:0] exp_data;
  logic              exp_wen, exp_fs;
  int                exp_slot;
  logic [NUM_CH-1:0] exp_ack;

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  bit                sb_on = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_started = 1'b0;
      m_pos     = 0;
      m_mask    = '0;
      for (int i = 0; i < NUM_CH; i++) m_snap[i] = '0;
      exp_data = '0; exp_wen = 1'b0; exp_fs = 1'b0; exp_slot = 0; exp_ack = '0;
    end else begin
      exp_wen = 1'b0;
      exp_ack = '0;
      if (bus.en) begin
        if (!m_started) begin
          m_started = 1'b1;
          m_pos     = 0;
        end else if (m_pos == 0) begin
          for (int i = 0; i < NUM_CH; i++) m_snap[i] = bus.ch_data[i*DATA_W +: DATA_W];
          m_mask   = bus.ch_valid;
          exp_data = SYNC_VAL;
          exp_wen  = 1'b1;
          exp_fs   = 1'b1;
          exp_slot = 0;
          exp_ack  = bus.ch_valid;
          m_pos    = 1;
        end else begin
          exp_data = m_mask[m_pos-1] ? m_snap[m_pos-1] : IDLE_VAL;
          exp_wen  = 1'b1;
          exp_fs   = 1'b0;
          exp_slot = m_pos;
          m_pos    = (m_pos == NUM_CH) ? 0 : m_pos + 1;
        end
      end
    end
    #1;
    chk("m_out_data", 32'(bus.out_data), 32'(exp_data));
    chk("m_out_wen", 32'(bus.out_wen), 32'(exp_wen));
    chk("m_frame_start", 32'(bus.frame_start), 32'(exp_fs));
    chk("m_slot", 32'(bus.slot), exp_slot);
    chk("m_ch_ack", 32'(bus.ch_ack), 32'(exp_ack));
    if (sb_on && bus.out_wen) begin
      if (exp_q.size() == 0) chk("sb_extra_write", 32'(bus.out_data), 32'hFFFF_FFFF);
      else chk("sb_word", 32'(bus.out_data), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic [NUM_CH*DATA_W-1:0] data, input logic [NUM_CH-1:0] valid);
    rst = 1'b1;
    bus.en = 1'b0;
    bus.ch_data = data;
    bus.ch_valid = valid;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_frame(input logic [DATA_W-1:0] w1, w2, w3, w4);
    exp_q.push_back(SYNC_VAL);
    exp_q.push_back(w1);
    exp_q.push_back(w2);
    exp_q.push_back(w3);
    exp_q.push_back(w4);
  endtask

  task automatic drain(input string name);
    sb_on = 1'b0;
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- directed tests ----------------
  int ack_cnt;

  initial begin
    bus.en = 1'b0;
    bus.ch_data = '0;
    bus.ch_valid = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_out_wen", 32'(bus.out_wen), 0);
    chk("rst_slot", 32'(bus.slot), 0);
    chk("rst_ch_ack", 32'(bus.ch_ack), 0);

    // 1: all valid, words 4,3,2,1 on ch3..ch0
    do_reset(16'h4321, 4'hF);
    push_frame(4'h1, 4'h2, 4'h3, 4'h4);
    push_frame(4'h1, 4'h2, 4'h3, 4'h4);
    sb_on = 1'b1;
    bus.en = 1'b1;
    @(negedge clk);
    chk("t1_idle_no_write", 32'(bus.out_wen), 0);
    @(negedge clk);
    chk("t1_sync_word", 32'(bus.out_data), 32'hA);
    chk("t1_sync_fs", 32'(bus.frame_start), 1);
    chk("t1_sync_ack", 32'(bus.ch_ack), 32'hF);
    @(negedge clk);
    chk("t1_slot1_word", 32'(bus.out_data), 32'h1);
    chk("t1_slot1_slot", 32'(bus.slot), 1);
    repeat (8) @(negedge clk);
    drain("t1_stream_len");

    // 2: sparse valid mask
    do_reset(16'h7777, 4'b0101);
    push_frame(4'h7, 4'h0, 4'h7, 4'h0);
    sb_on = 1'b1;
    bus.en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t2_sync_ack", 32'(bus.ch_ack), 32'h5);
    @(negedge clk);
    chk("t2_ack_gone", 32'(bus.ch_ack), 0);
    repeat (3) @(negedge clk);
    chk("t2_slot4_idle", 32'(bus.out_data), 32'h0);
    chk("t2_slot4_slot", 32'(bus.slot), 4);
    drain("t2_stream_len");

    // 3: stall for 3 edges after slot 2
    do_reset(16'h4321, 4'hF);
    push_frame(4'h1, 4'h2, 4'h3, 4'h4);
    exp_q.push_back(SYNC_VAL);
    sb_on = 1'b1;
    bus.en = 1'b1;
    repeat (4) @(negedge clk);
    chk("t3_slot2_word", 32'(bus.out_data), 32'h2);
    bus.en = 1'b0;
    @(negedge clk);
    chk("t3_stall_wen", 32'(bus.out_wen), 0);
    chk("t3_stall_hold", 32'(bus.out_data), 32'h2);
    chk("t3_stall_slot", 32'(bus.slot), 2);
    repeat (2) @(negedge clk);
    bus.en = 1'b1;
    @(negedge clk);
    chk("t3_resume_word", 32'(bus.out_data), 32'h3);
    chk("t3_resume_slot", 32'(bus.slot), 3);
    repeat (2) @(negedge clk);
    drain("t3_stream_len");

    // 4: data change right after the SYNC capture
    do_reset(16'h4321, 4'hF);
    push_frame(4'h1, 4'h2, 4'h3, 4'h4);
    push_frame(4'hF, 4'hF, 4'hF, 4'hF);
    sb_on = 1'b1;
    bus.en = 1'b1;
    repeat (2) @(negedge clk);
    bus.ch_data = 16'hFFFF;
    repeat (9) @(negedge clk);
    drain("t4_stream_len");

    // 5: asynchronous reset mid-frame
    do_reset(16'h4321, 4'hF);
    bus.en = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_data", 32'(bus.out_data), 0);
    chk("t5_async_wen", 32'(bus.out_wen), 0);
    chk("t5_async_slot", 32'(bus.slot), 0);
    bus.en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(SYNC_VAL);
    exp_q.push_back(4'h1);
    sb_on = 1'b1;
    bus.en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_restart_word", 32'(bus.out_data), 32'hA);
    chk("t5_restart_slot", 32'(bus.slot), 0);
    @(negedge clk);
    drain("t5_stream_len");

    // 6: en low on the SYNC edge
    do_reset(16'h4321, 4'hF);
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    @(negedge clk);
    chk("t6_stalled_ack", 32'(bus.ch_ack), 0);
    chk("t6_stalled_wen", 32'(bus.out_wen), 0);
    bus.en = 1'b1;
    @(negedge clk);
    chk("t6_late_ack", 32'(bus.ch_ack), 32'hF);
    chk("t6_late_sync", 32'(bus.out_data), 32'hA);
    ack_cnt = int'(bus.ch_ack[0]);
    repeat (4) begin
      @(negedge clk);
      ack_cnt += int'(bus.ch_ack[0]);
    end
    chk("t6_one_ack_per_frame", ack_cnt, 1);
    @(negedge clk);
    chk("t6_next_frame_ack", 32'(bus.ch_ack), 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tdm_frame_mux.md
Name: tdm_frame_mux

Overview:
- Upstream stage of the TDM queue: interleaves NUM_CH parallel channel words into one serial word stream, one word per clock.
- Builds repeating frames of one sync slot followed by NUM_CH data slots.
- Drives the queue's data input and write enable directly; stalls with the shared `en`.

Parameters:
NUM_CH, 4, number of multiplexed channels (2..8)
DATA_W, 4, width of each channel word and of the serial output
SYNC_WORD, 4'hA, word emitted in slot 0 of every frame
IDLE_WORD, 4'h0, word emitted in a data slot whose channel had no valid word at frame start

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  global enable; low = stall, shared with the queue
ch_data  input  NUM_CH*DATA_W  channel words; channel i at [i*DATA_W +: DATA_W]
ch_valid  input  NUM_CH  channel i has a word to send
ch_ack  output  NUM_CH  one-cycle pulse: channel i word captured this frame
out_data  output  DATA_W  serial word to the queue in1
out_wen  output  1  write strobe to the queue w_en
frame_start  output  1  high while out_data carries SYNC_WORD
slot  output  $clog2(NUM_CH+1)  slot index of the current out_data (0 = sync, i+1 = channel i)

Behaviour:
- Reset (rst=1, asynchronous, at any time): state IDLE; out_data=0, out_wen=0, frame_start=0, slot=0, ch_ack=0; snapshot registers and valid mask cleared. Reset mid-frame abandons the frame; no partial frame resumes.
- All outputs are registered; values change only on a rising clk edge or on reset.
- States: IDLE, SYNC, DATA.
- IDLE: outputs held at reset values. When en=1 at an edge, go to SYNC.
- SYNC edge (en=1): out_data=SYNC_WORD, out_wen=1, frame_start=1, slot=0. Capture ch_data[i] into snap[i] and ch_valid[i] into mask[i] for every channel. Set ch_ack=ch_valid, pulsed for exactly this one cycle. Next state DATA with index k=0.
- DATA edge (en=1):
  - out_data = mask[k] ? snap[k] : IDLE_WORD; out_wen=1; frame_start=0; slot=k+1; ch_ack=0.
  - If k=NUM_CH-1, next state SYNC; otherwise k increments.
- Frame length is exactly NUM_CH+1 enabled cycles; frames run back-to-back with no gap.
- Latency: a channel i word captured at SYNC edge E appears on out_data at enabled edge E+1+i.
- Stall (en=0 at an edge):
  - State, k, snap and mask are held.
  - out_wen=0 and ch_ack=0 for that cycle; out_data, slot and frame_start hold their last values.
  - The sequence resumes at the same slot on the next enabled edge.
- ch_valid and ch_data changes after the SYNC capture are ignored until the next SYNC. A source holding ch_valid high is acked once per frame.
- Channels whose ch_valid is low at SYNC receive no ack; their slot carries IDLE_WORD.
- Simultaneous events: a SYNC edge with en=0 performs no capture, no ack and no write; capture happens on the first enabled SYNC edge.
- Width rules: k counter is $clog2(NUM_CH) bits; slot is k+1, zero-extended to its port width. No arithmetic on data.

Decomposition:
- Package tdm_pkg: DATA_W default, SYNC_WORD, IDLE_WORD, state enum {IDLE, SYNC, DATA}, slot width function.
- One sub-module, tdm_slot_counter: enabled modulo-NUM_CH counter with wrap flag.
- Top level holds the FSM, snapshot/mask registers and output registers.

Test Plan:
1. Reset then en=1, NUM_CH=4, all valid, ch_data=4'h4,3,2,1 (ch3..ch0) -> out_data A,1,2,3,4,A,1,... with out_wen=1 every cycle; frame_start=1 only on A; slot 0,1,2,3,4 repeating.
2. ch_valid=4'b0101, data 4'h7 on every channel -> frame A,7,0,7,0; ch_ack=4'b0101 for exactly the SYNC cycle only.
3. en=0 for 3 cycles after the slot-2 output -> out_wen=0 for those 3 cycles, out_data held; then slot 3 follows with the correct snapshot word. Frame totals 5 writes.
4. ch_data change to 4'hF immediately after the SYNC edge -> current frame still emits the old words; next frame emits F.
5. rst pulsed asynchronously mid-slot 2 -> outputs 0 immediately, without waiting for clk; after release and en=1, the next output is A with slot 0.
6. en low on the SYNC edge while ch_valid=1 -> no ch_ack and no write. Ack and capture occur on the first enabled edge; exactly one ack per frame.
